// File: rtl/ldpc_3gpp_dec_sched_pkg.sv
// Shared types for the ldpc_3gpp decoder frame scheduler: engine index/mask,
// FSM state encodings and the one-hot helper.
package ldpc_3gpp_dec_sched_pkg;

  localparam int cENGINE_NUM_MAX = 8;
  localparam int cINFLIGHT_W     = 4;

  typedef logic [2:0]                 engine_idx_t;
  typedef logic [cENGINE_NUM_MAX-1:0] engine_mask_t;

  typedef enum logic {
    cIN_WAIT,
    cIN_FRAME
  } in_state_t;

  typedef enum logic [2:0] {
    cO_WAIT,
    cO_START,
    cO_READ,
    cO_RELEASE,
    cO_HOLD
  } out_state_t;

  function automatic engine_mask_t onehot(engine_idx_t idx);
    engine_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_sched_ptr.sv
// Wrapping round-robin engine index: advances on iinc while enabled,
// pNUM-1 wraps to 0.
module ldpc_3gpp_dec_sched_ptr #(
  parameter int pNUM = 4,
  parameter int pW   = 2
) (
  input  logic          iclk,
  input  logic          ireset_n,
  input  logic          iclkena,
  input  logic          iinc,
  output logic [pW-1:0] optr
);

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n)
      optr <= '0;
    else if (iclkena && iinc)
      optr <= (optr == pW'(pNUM - 1)) ? '0 : optr + 1'b1;
  end

endmodule

// File: rtl/ldpc_3gpp_dec_sched.sv
// Round-robin frame scheduler: hands each incoming LLR frame to the next engine
// input buffer and drains engine outputs to a single reader in arrival order.
module ldpc_3gpp_dec_sched
  import ldpc_3gpp_dec_sched_pkg::*;
#(
  parameter int pENGINE_NUM = 4
) (
  input  logic                   iclk,
  input  logic                   ireset_n,
  input  logic                   iclkena,
  input  logic                   isop,
  input  logic                   ival,
  input  logic                   ieop,
  output logic                   ordy,
  output logic [pENGINE_NUM-1:0] owr_sel,
  input  logic [pENGINE_NUM-1:0] iengine_ibuf_rdy,
  output logic [pENGINE_NUM-1:0] oengine_ibuf_full,
  input  logic [pENGINE_NUM-1:0] iengine_obuf_full,
  output logic [pENGINE_NUM-1:0] oengine_obuf_empty,
  output logic                   orstart,
  output logic [pENGINE_NUM-1:0] orsel,
  input  logic                   iout_done,
  output logic [3:0]             oinflight,
  output logic                   osync_err
);

  localparam int pENGINE_W = (pENGINE_NUM > 1) ? $clog2(pENGINE_NUM) : 1;
  // The 4-bit counter tops out at 15, so 8 engines get one slot less than 2*N.
  localparam int cMAX_INFLIGHT = (2 * pENGINE_NUM > 15) ? 15 : 2 * pENGINE_NUM;

  logic [pENGINE_W-1:0]   wr_ptr, rd_ptr;
  logic [pENGINE_NUM-1:0] wr_mask, rd_mask;
  logic                   wr_inc, rd_inc;
  logic                   wr_evt, rel_evt;
  logic [4:0]             inflight_pend;
  logic                   wr_room;
  logic                   in_word;
  in_state_t              in_state;
  out_state_t             out_state;

  assign wr_mask = pENGINE_NUM'(onehot(engine_idx_t'(wr_ptr)));
  assign rd_mask = pENGINE_NUM'(onehot(engine_idx_t'(rd_ptr)));

  assign wr_inc  = (in_state == cIN_FRAME) && ival && ieop;
  assign rd_inc  = (out_state == cO_READ) && iout_done;

  assign wr_evt  = |oengine_ibuf_full;
  assign rel_evt = |oengine_obuf_empty;

  // A frame-written pulse still on the wire is not yet in oinflight; count it
  // so back-to-back short frames cannot overshoot the limit.
  assign inflight_pend = {1'b0, oinflight} + 5'(wr_evt);
  assign wr_room       = inflight_pend < 5'(cMAX_INFLIGHT);

  ldpc_3gpp_dec_sched_ptr #(.pNUM(pENGINE_NUM), .pW(pENGINE_W)) u_wr_ptr (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclkena  (iclkena),
    .iinc     (wr_inc),
    .optr     (wr_ptr)
  );

  ldpc_3gpp_dec_sched_ptr #(.pNUM(pENGINE_NUM), .pW(pENGINE_W)) u_rd_ptr (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclkena  (iclkena),
    .iinc     (rd_inc),
    .optr     (rd_ptr)
  );

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      in_state          <= cIN_WAIT;
      ordy              <= 1'b0;
      owr_sel           <= '0;
      oengine_ibuf_full <= '0;
      osync_err         <= 1'b0;
      in_word           <= 1'b0;
    end else if (iclkena) begin
      oengine_ibuf_full <= '0;
      if (ival && (!ordy || (isop && in_word)))
        osync_err <= 1'b1;
      case (in_state)
        cIN_WAIT: begin
          if (iengine_ibuf_rdy[wr_ptr] && wr_room) begin
            in_state <= cIN_FRAME;
            ordy     <= 1'b1;
            owr_sel  <= wr_mask;
          end
        end
        cIN_FRAME: begin
          if (ival) begin
            in_word <= !ieop;
            if (ieop) begin
              in_state          <= cIN_WAIT;
              ordy              <= 1'b0;
              owr_sel           <= '0;
              oengine_ibuf_full <= wr_mask;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      out_state          <= cO_WAIT;
      orstart            <= 1'b0;
      orsel              <= '0;
      oengine_obuf_empty <= '0;
    end else if (iclkena) begin
      case (out_state)
        cO_WAIT: begin
          if (iengine_obuf_full[rd_ptr]) begin
            out_state <= cO_START;
            orstart   <= 1'b1;
            orsel     <= rd_mask;
          end
        end
        cO_START: begin
          orstart   <= 1'b0;
          out_state <= cO_READ;
        end
        cO_READ: begin
          if (iout_done) begin
            out_state          <= cO_RELEASE;
            oengine_obuf_empty <= rd_mask;
          end
        end
        cO_RELEASE: begin
          oengine_obuf_empty <= '0;
          orsel              <= '0;
          out_state          <= cO_HOLD;
        end
        cO_HOLD:  out_state <= cO_WAIT;
        default:  out_state <= cO_WAIT;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n)
      oinflight <= '0;
    else if (iclkena) begin
      case ({wr_evt, rel_evt})
        2'b10:   if (oinflight != 4'(cMAX_INFLIGHT)) oinflight <= oinflight + 1'b1;
        2'b01:   if (oinflight != '0) oinflight <= oinflight - 1'b1;
        default: oinflight <= oinflight;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_dec_sched.sv
// Bench for ldpc_3gpp_dec_sched: random source/engine/reader models around the
// scheduler, a frame-level reference (round-robin order, in-flight count) and
// directed sequences for stalls, coincident events, fill limit and resets.
module tb_ldpc_3gpp_dec_sched;

  localparam int N = 4;

  logic         iclk = 1'b0, ireset_n = 1'b1, iclkena = 1'b0;
  logic         isop = 1'b0, ival = 1'b0, ieop = 1'b0, iout_done = 1'b0;
  logic         ordy, orstart, osync_err;
  logic [N-1:0] owr_sel, oengine_ibuf_full, oengine_obuf_empty, orsel;
  logic [N-1:0] iengine_ibuf_rdy = '0, iengine_obuf_full = '0;
  logic [3:0]   oinflight;

  always #5 iclk = ~iclk;

  ldpc_3gpp_dec_sched #(.pENGINE_NUM(N)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena),
    .isop(isop), .ival(ival), .ieop(ieop), .ordy(ordy), .owr_sel(owr_sel),
    .iengine_ibuf_rdy(iengine_ibuf_rdy), .oengine_ibuf_full(oengine_ibuf_full),
    .iengine_obuf_full(iengine_obuf_full), .oengine_obuf_empty(oengine_obuf_empty),
    .orstart(orstart), .orsel(orsel), .iout_done(iout_done),
    .oinflight(oinflight), .osync_err(osync_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] m;
    m = '0;
    if (i >= 0 && i < N) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int idx_of(logic [N-1:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  // environment / model state
  int           cyc_n = 0;
  bit           en_rand, src_hold, force_ival, eng_block;
  int           src_frames, src_words, word_idx;
  bit           acc_prev, eop_prev;
  logic [N-1:0] rdy_mask;
  int           eng_q[N][$];
  int           lat_lo = 2, lat_hi = 8, rd_lo = 1, rd_hi = 4;
  int           lat_over[$];
  bit           rd_busy, rd_manual, rd_fire;
  int           rd_cnt, rd_cur;
  int           exp_wr, exp_rd, rel_cnt, model_inf;
  bit           exp_err;
  int           wr_log[$], rd_log[$];

  task automatic cyc();
    bit en;
    int k, lat, t;
    @(negedge iclk);
    cyc_n++;
    en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (acc_prev) begin
      if (word_idx == src_words - 1) begin word_idx = 0; src_frames--; end
      else word_idx++;
    end
    if (eop_prev) chk("ibuf_full_at_eop1", oengine_ibuf_full, oh(exp_wr % N));
    chk("owr_sel", owr_sel, ordy ? oh(exp_wr % N) : '0);
    chk("inflight", oinflight, model_inf);
    chk("sync_err", osync_err, exp_err);
    if (rd_busy) chk("orsel_stable", orsel, oh(rd_cur));
    if (en) begin
      if (oengine_ibuf_full != '0) begin
        k = idx_of(oengine_ibuf_full);
        chk("wr_order", k, exp_wr % N);
        k = exp_wr % N;
        wr_log.push_back(idx_of(oengine_ibuf_full));
        if (lat_over.size() > 0) lat = lat_over.pop_front();
        else lat = $urandom_range(lat_lo, lat_hi);
        t = cyc_n + lat;
        if (eng_q[k].size() > 0 && t <= eng_q[k][$]) t = eng_q[k][$] + 1;
        eng_q[k].push_back(t);
        exp_wr++;
        model_inf++;
      end
      if (oengine_obuf_empty != '0) begin
        chk("release_sel", oengine_obuf_empty, oh(rd_cur));
        if (eng_q[rd_cur].size() > 0) void'(eng_q[rd_cur].pop_front());
        rel_cnt++;
        model_inf--;
      end
      if (orstart) begin
        k = idx_of(orsel);
        chk("rd_order", k, exp_rd % N);
        rd_log.push_back(k);
        rd_busy = 1'b1;
        rd_cur  = exp_rd % N;
        rd_cnt  = $urandom_range(rd_lo, rd_hi);
        exp_rd++;
      end
    end
    // drive inputs for the coming edge
    iclkena          = en;
    iengine_ibuf_rdy = rdy_mask;
    for (int e = 0; e < N; e++)
      iengine_obuf_full[e] = !eng_block && eng_q[e].size() > 0 && cyc_n >= eng_q[e][0];
    ival     = force_ival || (src_frames > 0 && !src_hold && ordy);
    isop     = (word_idx == 0);
    ieop     = (word_idx == src_words - 1);
    acc_prev = en && ordy && ival;
    eop_prev = acc_prev && ieop;
    iout_done = 1'b0;
    if (rd_busy && en) begin
      if (rd_manual ? rd_fire : (rd_cnt == 0)) begin
        iout_done = 1'b1;
        rd_busy   = 1'b0;
        rd_fire   = 1'b0;
      end else if (rd_cnt > 0) rd_cnt--;
    end
  endtask

  task automatic do_reset(int hold);
    @(negedge iclk);
    ireset_n = 1'b0;
    {ival, isop, ieop, iout_done} = '0;
    iengine_obuf_full = '0;
    iengine_ibuf_rdy  = '0;
    iclkena = 1'b1;
    #1;
    chk("reset_outputs", {ordy, orstart, osync_err, owr_sel, oengine_ibuf_full,
                          oengine_obuf_empty, orsel, oinflight}, '0);
    repeat (hold) @(negedge iclk);
    chk("reset_outputs_held", {ordy, orstart, osync_err, owr_sel, oengine_ibuf_full,
                               oengine_obuf_empty, orsel, oinflight}, '0);
    {en_rand, src_hold, force_ival, eng_block, acc_prev, eop_prev} = '0;
    {rd_busy, rd_manual, rd_fire, exp_err} = '0;
    src_frames = 0; src_words = 1; word_idx = 0;
    exp_wr = 0; exp_rd = 0; rel_cnt = 0; model_inf = 0; rd_cur = 0; rd_cnt = 0;
    rdy_mask = '1;
    for (int e = 0; e < N; e++) eng_q[e].delete();
    lat_over.delete(); wr_log.delete(); rd_log.delete();
    iclkena  = 1'b0;
    ireset_n = 1'b1;
  endtask

  task automatic run_wr(int target, int budget, string name);
    int n = 0;
    while (exp_wr < target && n < budget) begin cyc(); n++; end
    chk({name, "_wr_done"}, exp_wr, target);
  endtask

  task automatic run_rel(int target, int budget, string name);
    int n = 0;
    while (rel_cnt < target && n < budget) begin cyc(); n++; end
    chk({name, "_rel_done"}, rel_cnt, target);
  endtask

  typedef struct {
    int          frames;
    int          words;
    bit          en_rand;
    int          lat_lo, lat_hi, rd_lo, rd_hi;
    logic [31:0] exp_sel;    // owr_sel of frames 0..7, one nibble each, LSB first
    int          exp_pulses;
  } scen_t;

  scen_t tab[4];

  initial begin
    int n, cnt;
    tab[0] = '{8,  5, 1'b0, 3, 10, 2, 6, 32'h8421_8421, 8};
    tab[1] = '{8,  5, 1'b1, 3, 10, 2, 6, 32'h8421_8421, 8};
    tab[2] = '{12, 1, 1'b0, 1, 30, 1, 4, 32'h8421_8421, 12};
    tab[3] = '{10, 3, 1'b1, 1, 40, 1, 8, 32'h8421_8421, 10};

    for (int s = 0; s < 4; s++) begin
      do_reset(2);
      en_rand = tab[s].en_rand;
      lat_lo = tab[s].lat_lo; lat_hi = tab[s].lat_hi;
      rd_lo  = tab[s].rd_lo;  rd_hi  = tab[s].rd_hi;
      src_words  = tab[s].words;
      src_frames = tab[s].frames;
      run_rel(tab[s].exp_pulses, 6000, "scen");
      chk("scen_wr_pulses", exp_wr, tab[s].exp_pulses);
      chk("scen_rd_starts", exp_rd, tab[s].exp_pulses);
      for (int i = 0; i < 8; i++)
        chk("scen_wr_sel", (i < wr_log.size()) ? oh(wr_log[i]) : '0, tab[s].exp_sel[4*i +: 4]);
      en_rand = 1'b0;
      repeat (3) cyc();
      chk("scen_inflight_zero", oinflight, 0);
    end

    // engine 2 decodes before engine 1: reader still waits for engine 1
    do_reset(1);
    src_words = 4; lat_over = '{3, 80, 3}; rd_lo = 2; rd_hi = 3;
    src_frames = 3;
    run_rel(3, 2000, "order");
    chk("order_rd0", (rd_log.size() > 0) ? rd_log[0] : -1, 0);
    chk("order_rd1", (rd_log.size() > 1) ? rd_log[1] : -1, 1);
    chk("order_rd2", (rd_log.size() > 2) ? rd_log[2] : -1, 2);

    // engine 1 input buffer busy for 20 cycles after frame 0
    do_reset(1);
    rdy_mask = 4'b1101; src_words = 3; src_frames = 2;
    run_wr(1, 200, "stall");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (ordy) cnt++; end
    chk("stall_ordy_low", cnt, 0);
    rdy_mask = '1;
    run_rel(2, 1000, "stall");
    chk("stall_frame1_engine", (wr_log.size() > 1) ? wr_log[1] : -1, 1);

    // write and release on the same cycle, then fill to the limit
    do_reset(1);
    lat_lo = 2; lat_hi = 4; rd_lo = 2; rd_hi = 4;
    eng_block = 1'b1; src_words = 1; src_frames = 3;
    run_wr(3, 200, "coinc_pre");
    src_frames = 7; src_hold = 1'b1; rd_manual = 1'b1; eng_block = 1'b0;
    n = 0;
    while (!(rd_busy && ordy) && n < 500) begin cyc(); n++; end
    chk("coinc_setup_reached", n < 500, 1);
    chk("coinc_pre_inflight", oinflight, 3);
    eng_block = 1'b1; src_hold = 1'b0; rd_fire = 1'b1;
    cyc();
    cyc();
    chk("coinc_both_pulses", {|oengine_ibuf_full, |oengine_obuf_empty}, 2'b11);
    cyc();
    chk("coinc_inflight_kept", oinflight, 3);
    run_wr(9, 1000, "fill");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (ordy) cnt++; end
    chk("fill_ordy_held", cnt, 0);
    chk("fill_inflight", oinflight, 8);
    chk("fill_frame_pending", src_frames, 1);
    eng_block = 1'b0; rd_manual = 1'b0;
    run_rel(10, 3000, "fill_drain");

    // ival while ordy low is sticky until reset
    do_reset(1);
    rdy_mask = '0;
    cyc();
    force_ival = 1'b1;
    cyc();
    force_ival = 1'b0;
    exp_err = 1'b1;
    repeat (10) cyc();
    chk("sync_err_sticky", osync_err, 1);

    // reset in the middle of frame 1, then two clean frames
    do_reset(1);
    src_words = 6; src_frames = 3;
    n = 0;
    while (!(exp_wr == 1 && word_idx == 2) && n < 500) begin cyc(); n++; end
    chk("midrst_reached", n < 500, 1);
    do_reset(3);
    src_words = 3; src_frames = 2;
    run_rel(2, 1000, "midrst");
    chk("midrst_frame0_engine", (wr_log.size() > 0) ? wr_log[0] : -1, 0);
    chk("midrst_frame1_engine", (wr_log.size() > 1) ? wr_log[1] : -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
